seg_scan_display: RTL and testbench

Parametrised time-multiplexed seven-segment display driver for N hex digits. It holds a shift-in digit register, loaded one nibble per `push` strobe from the keypad/entry path. It scans one digit at a time at a programmable refresh rate, inserts dead-time between digits to suppress ghosting, and blanks digit positions that have not been written since reset or `clear`. It sits between the keypad decode/debounce logic and the board's shared segment bus plus per-digit enables.

---
 rtl/seg_pkg.sv | 32 +++
 rtl/seg_hex_decoder.sv | 13 +
 rtl/seg_scan_display.sv | 138 +++++++++++++
 tb/tb_seg_scan_display.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg -- shared types and constants for the seven-segment scan driver.
//   hex_t      : one hex digit (4 bits)
//   seg_t      : segment vector {g,f,e,d,c,b,a}, active-high in the core
//   SEG_BLANK  : active-high "nothing lit" pattern
//   SEG_GLYPHS : active-high glyphs for 0..F (b and d drawn lowercase)
package seg_pkg;

  typedef logic [3:0] hex_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t SEG_GLYPHS [16] = '{
    7'h3F,  // 0
    7'h06,  // 1
    7'h5B,  // 2
    7'h4F,  // 3
    7'h66,  // 4
    7'h6D,  // 5
    7'h7D,  // 6
    7'h07,  // 7
    7'h7F,  // 8
    7'h6F,  // 9
    7'h77,  // A
    7'h7C,  // b
    7'h39,  // C
    7'h5E,  // d
    7'h79,  // E
    7'h71   // F
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder -- combinational hex to seven-segment lookup.
//   hex    : input digit 0..F
//   seg_hi : active-high segment pattern {g,f,e,d,c,b,a}
module seg_hex_decoder
  import seg_pkg::*;
(
  input  hex_t hex,
  output seg_t seg_hi
);

  assign seg_hi = SEG_GLYPHS[hex];

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display -- time-multiplexed N-digit seven-segment driver.
// Holds a shift-in digit store (newest digit at position 0), scans one
// position per REFRESH_DIV cycles with DEAD_CYCLES of all-off at the start of
// each slot, and blanks positions that were never written since reset/clear.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   push     : strobe, shifts digit into position 0
//   digit    : hex value sampled with push
//   clear    : synchronous clear of the store (wins over push)
//   seg      : registered segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   an       : registered one-hot digit enables, polarity per AN_ACTIVE_LOW
//   scan_idx : slot whose outputs are currently on seg/an
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 0,
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [3:0]            digit,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SLOT_W-1:0]     scan_idx
);

  localparam int DIV_W = $clog2(REFRESH_DIV);

  // Idle levels at the pins; polarity is only ever applied at the output flops.
  localparam seg_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [DIV_W-1:0]      div_q, div_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  hex_t                  d_q [NUM_DIGITS];
  hex_t                  d_d [NUM_DIGITS];
  logic                  v_q [NUM_DIGITS];
  logic                  v_d [NUM_DIGITS];
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [SLOT_W-1:0]     scan_idx_q, scan_idx_d;

  hex_t                  hex_sel;
  seg_t                  glyph_hi;
  seg_t                  seg_hi;
  logic [NUM_DIGITS-1:0] an_hi;
  logic                  in_dead;

  // Free-running scanner: push/clear never disturb the phase.
  always_comb begin
    div_d  = div_q + 1'b1;
    slot_d = slot_q;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d  = '0;
      slot_d = (slot_q == SLOT_W'(NUM_DIGITS - 1)) ? '0 : slot_q + 1'b1;
    end
  end

  // Shift store: clear has priority, the oldest digit falls off the end.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d_d[i] = d_q[i];
      v_d[i] = v_q[i];
    end
    if (clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d_d[i] = '0;
        v_d[i] = 1'b0;
      end
    end else if (push) begin
      for (int i = 1; i < NUM_DIGITS; i++) begin
        d_d[i] = d_q[i-1];
        v_d[i] = v_q[i-1];
      end
      d_d[0] = digit;
      v_d[0] = 1'b1;
    end
  end

  assign hex_sel = d_q[slot_q];

  seg_hex_decoder u_dec (
    .hex    (hex_sel),
    .seg_hi (glyph_hi)
  );

  // Next outputs from the current scanner state, so pins lag div/slot by one.
  always_comb begin
    in_dead = (32'(div_q) < DEAD_CYCLES);
    an_hi   = '0;
    seg_hi  = SEG_BLANK;
    if (!in_dead) begin
      an_hi[slot_q] = 1'b1;
      if (v_q[slot_q]) begin
        seg_hi = glyph_hi;
      end
    end
    seg_d      = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    an_d       = (AN_ACTIVE_LOW != 0) ? ~an_hi : an_hi;
    scan_idx_d = slot_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      slot_q     <= '0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
      scan_idx_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d_q[i] <= '0;
        v_q[i] <= 1'b0;
      end
    end else begin
      div_q      <= div_d;
      slot_q     <= slot_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      scan_idx_q <= scan_idx_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        d_q[i] <= d_d[i];
        v_q[i] <= v_d[i];
      end
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

  localparam int ND   = 2;
  localparam int RDIV = 4;
  localparam int DEAD = 1;

  // Reference glyphs, active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          push  = 1'b0;
  logic          clear = 1'b0;
  logic [3:0]    digit = 4'h0;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic [0:0]    scan_idx;

  seg_scan_display #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RDIV),
    .DEAD_CYCLES    (DEAD),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .digit    (digit),
    .clear    (clear),
    .seg      (seg),
    .an       (an),
    .scan_idx (scan_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic [0:0]    idx;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state
  int         m_div;
  int         m_slot;
  logic [3:0] m_d [ND];
  logic       m_v [ND];

  // Period monitor
  bit period_en = 1'b0;
  bit have_last = 1'b0;
  int cyc       = 0;
  int last_rise = 0;
  logic [ND-1:0] prev_an = '0;

  task automatic check(input string tag, input int obs, input int req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  // Model: on each edge, push the expected registered outputs, then advance.
  always @(posedge clk or negedge reset) begin
    exp_t e;
    if (!reset) begin
      m_div  = 0;
      m_slot = 0;
      for (int i = 0; i < ND; i++) begin
        m_d[i] = 4'h0;
        m_v[i] = 1'b0;
      end
      sb_q.delete();
    end else begin
      e.an  = '0;
      e.seg = 7'h7F;
      e.idx = 1'(m_slot);
      if (m_div >= DEAD) begin
        e.an[m_slot] = 1'b1;
        if (m_v[m_slot]) e.seg = ~GLYPH[m_d[m_slot]];
      end
      sb_q.push_back(e);
      if (clear) begin
        for (int i = 0; i < ND; i++) begin
          m_d[i] = 4'h0;
          m_v[i] = 1'b0;
        end
      end else if (push) begin
        for (int i = ND - 1; i > 0; i--) begin
          m_d[i] = m_d[i-1];
          m_v[i] = m_v[i-1];
        end
        m_d[0] = digit;
        m_v[0] = 1'b1;
      end
      if (m_div == RDIV - 1) begin
        m_div  = 0;
        m_slot = (m_slot + 1) % ND;
      end else begin
        m_div = m_div + 1;
      end
    end
  end

  // Scoreboard compare away from the active edge
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset || sb_q.size() == 0) begin
      e.seg = 7'h7F;
      e.an  = '0;
      e.idx = '0;
    end else begin
      e = sb_q.pop_front();
    end
    check("seg", int'(seg), int'(e.seg));
    check("an", int'(an), int'(e.an));
    check("scan_idx", int'(scan_idx), int'(e.idx));
    vectors++;
    assert ($onehot0(an)) else begin
      miscompares++;
      $error("FAIL an_onehot0: observed %b expected at most one bit set", an);
    end
    if (!period_en) begin
      have_last = 1'b0;
    end else if (prev_an == '0 && an != '0) begin
      if (have_last) check("slot_period", cyc - last_rise, RDIV);
      have_last = 1'b1;
      last_rise = cyc;
    end
    prev_an = an;
  end

  task automatic push_digit(input logic [3:0] val);
    push  = 1'b1;
    digit = val;
    @(negedge clk);
    push  = 1'b0;
  endtask

  initial begin
    int  c_a, c_b, c_c;
    bit  found;

    // Reset held for 3 cycles
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_seg", int'(seg), 'h7F);
      check("reset_an", int'(an), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_dead_an", int'(an), 0);

    // Single push of 3
    push_digit(4'h3);
    @(negedge clk);
    c_a = 0; c_b = 0; c_c = 0;
    repeat (16) begin
      @(negedge clk);
      if (an == 2'b01 && seg == 7'h30) c_a++;
      if (an == 2'b10 && seg == 7'h7F) c_b++;
      if (an == 2'b00) c_c++;
    end
    check("single_slot0_lit", c_a, 6);
    check("single_slot1_blank", c_b, 6);
    check("single_dead", c_c, 4);

    // Shift and overflow
    push_digit(4'h1);
    push_digit(4'h2);
    push_digit(4'h5);
    @(negedge clk);
    c_a = 0; c_b = 0;
    repeat (8) begin
      @(negedge clk);
      if (an == 2'b01 && seg == 7'h12) c_a++;
      if (an == 2'b10 && seg == 7'h24) c_b++;
    end
    check("overflow_slot0_5", c_a, 3);
    check("overflow_slot1_2", c_b, 3);

    // clear and push together: clear wins
    clear = 1'b1;
    push  = 1'b1;
    digit = 4'hA;
    @(negedge clk);
    clear = 1'b0;
    push  = 1'b0;
    @(negedge clk);
    c_a = 0; c_b = 0;
    repeat (8) begin
      @(negedge clk);
      if (an != 2'b00) c_a++;
      if (seg == 7'h7F) c_b++;
    end
    check("clear_an_active_cycles", c_a, 6);
    check("clear_all_blank", c_b, 8);

    // Reset mid-scan while an = 10
    push_digit(4'h7);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (an == 2'b10) found = 1'b1;
    end
    check("midscan_found_an10", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_an", int'(an), 0);
    check("async_reset_seg", int'(seg), 'h7F);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("release_cycle1_an", int'(an), 0);
    @(negedge clk);
    check("release_cycle2_an", int'(an), 1);

    // Random push/clear soak
    period_en = 1'b1;
    repeat (10000) begin
      push  = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 31) == 0);
      digit = 4'($urandom);
      @(negedge clk);
    end
    push      = 1'b0;
    clear     = 1'b0;
    period_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
